rv_imem_responder: RTL
======================

Name: rv_imem_responder

Overview:
- Instruction-memory responder on the fetch side of the core. It answers PC-driven fetch requests with instruction words after a configurable number of wait cycles.
- Word-addressed synchronous storage with a separate program-load write port used by the bench or boot loader.
- One outstanding fetch at a time. Out-of-range and misaligned fetches are flagged with an error response.

Parameters:
DEPTH, 256, number of 32-bit instruction words (power of two, 16..4096)
LATENCY, 1, cycles from accept to rvalid_o (1..8)
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
req_i  input  1  fetch request valid
addr_i  input  32  fetch byte address (PC)
gnt_o  output  1  request accepted this cycle (req_i && gnt_o)
rvalid_o  output  1  response valid, one-cycle pulse
rdata_o  output  32  instruction word, valid when rvalid_o
err_o  output  1  error response, valid when rvalid_o
load_we_i  input  1  program-load write enable
load_addr_i  input  $clog2(DEPTH)  program-load word index
load_data_i  input  32  program-load data

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, rvalid_o=0, rdata_o=0, err_o=0, wait counter=0. Memory contents are not reset.
- States:
  - IDLE: no fetch pending.
  - WAIT: counting remaining latency.
  - RESP: rvalid_o high this cycle.
- gnt_o is combinational: gnt_o = (state==IDLE) || (state==RESP). gnt_o is independent of req_i.
- Accept: a fetch is accepted on a cycle where req_i && gnt_o. At accept, addr_i is registered. gnt_o is 0 in WAIT, and the requester holds req_i/addr_i stable until granted.
- Transitions:
  - IDLE/RESP on accept, LATENCY==1: next state RESP.
  - IDLE/RESP on accept, LATENCY>1: next state WAIT, counter=LATENCY-2.
  - WAIT: decrement the counter; at 0, next state RESP.
  - RESP with no accept: next state IDLE.
- Latency: rvalid_o is asserted exactly LATENCY cycles after the accept edge. With LATENCY=1, back-to-back fetches run one per cycle.
- Address check, on the registered address:
  - off = addr - BASE_ADDR, computed mod 2^32.
  - Misaligned when off[1:0]!=0.
  - Out of range when off[31:2] >= DEPTH.
  - Either condition gives err_o=1 with rdata_o=32'h0000_0013 (NOP). Otherwise err_o=0 and rdata_o=mem[off[31:2]].
- Array read timing: the array is read on the cycle before RESP, so rdata_o is registered at the RESP entry edge.
- Load port: on load_we_i, mem[load_addr_i] <= load_data_i at the rising edge. The load port is always accepted, including during WAIT/RESP.
- Load/fetch collision: if a load write and the array read for a response target the same word on the same edge, the response returns the old data (read-before-write).
- Outputs outside RESP: rvalid_o=0 and err_o=0; rdata_o holds its last value.
- Reset mid-operation: a pending response is dropped and no rvalid_o follows. Loads performed before reset remain in memory.

Optional Feature:
- Macro RV_IMEM_STATS_EN.
- When defined:
  - Adds output port fetch_cnt_o [31:0].
  - The count increments on every accepted fetch, saturates at 32'hFFFF_FFFF, and resets to 0.
  - A separate output err_cnt_o [15:0] counts error responses, also saturating and reset to 0.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
- Load/fetch basic, LATENCY=1: load words 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013; request addr 0x0,0x4,0x8,0xC on consecutive cycles -> four consecutive rvalid_o pulses returning those words in order, err_o=0, gnt_o held 1.
- Wait states, LATENCY=3: fetch addr 0x4 -> gnt_o=0 for 2 cycles after accept; rvalid_o exactly 3 cycles after accept with 32'h00A00113; a second req_i held during WAIT is granted in the RESP cycle.
- Errors: fetch addr 0x6 -> err_o=1, rdata_o=32'h00000013. Fetch addr 4*DEPTH (0x400 at DEPTH=256) -> err_o=1. Fetch BASE_ADDR-4 (wrap) -> err_o=1.
- Collision: load_we_i to word 2 with 32'hDEADBEEF on the same edge as the array read for a pending fetch of 0x8 -> response returns 32'h002081B3; a subsequent fetch of 0x8 returns 32'hDEADBEEF.
- Reset mid-operation, LATENCY=4: accept fetch, pulse rst_i asynchronously (between clock edges) during WAIT -> rvalid_o never asserted, gnt_o=1 immediately after reset release, and previously loaded words still read back correctly.
- RV_IMEM_STATS_EN: 10 fetches including 3 erroneous -> fetch_cnt_o=10, err_cnt_o=3; after rst_i both counters = 0.

Source files
------------

// File: rtl/rv_imem_responder.sv
// rv_imem_responder: instruction-memory fetch responder.
// Word-addressed storage with a separate program-load write port. Each accepted
// fetch is answered LATENCY cycles later with one rvalid_o pulse. A misaligned or
// out-of-range fetch answers with err_o=1 and a NOP word.
// Optional build macro RV_IMEM_STATS_EN adds the fetch_cnt_o/err_cnt_o counters.
module rv_imem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic [31:0]              addr_i,
    output logic                     gnt_o,
    output logic                     rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    input  logic                     load_we_i,
    input  logic [$clog2(DEPTH)-1:0] load_addr_i,
    input  logic [31:0]              load_data_i
`ifdef RV_IMEM_STATS_EN
    ,
    output logic [31:0]              fetch_cnt_o,
    output logic [15:0]              err_cnt_o
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam bit          SINGLE   = (LATENCY == 1);
    localparam logic [2:0]  CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_rvalid;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH];

    logic          w_gnt;
    logic          w_accept;
    logic          w_resp_entry;
    logic [31:0]   w_chk_addr;
    logic [31:0]   w_off;
    logic          w_misal;
    logic          w_oor;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign w_gnt    = (r_state == S_IDLE) || (r_state == S_RESP);
    assign w_accept = req_i && w_gnt;

    // The edge that enters RESP is also the array-read edge. With a single-cycle
    // latency that is the accept edge itself, so the incoming address is checked
    // directly instead of the (not yet loaded) address register.
    assign w_resp_entry = (w_accept && SINGLE) || ((r_state == S_WAIT) && (r_cnt == 3'd0));
    assign w_chk_addr   = w_accept ? addr_i : r_addr;

    assign w_off   = w_chk_addr - BASE_ADDR;
    assign w_misal = |w_off[1:0];
    assign w_oor   = |w_off[31:AW+2];
    assign w_err   = w_misal || w_oor;
    assign w_idx   = w_off[AW+1:2];

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

    // Fetch FSM with registered response outputs; the array read uses the old
    // word when a load hits the same entry on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            if (w_resp_entry) begin
                r_rvalid <= 1'b1;
                r_err    <= w_err;
                r_rdata  <= w_err ? NOP_WORD : r_mem[w_idx];
            end
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_addr <= addr_i;
                        if (SINGLE) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Program-load write port, always accepted; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            r_mem[load_addr_i] <= load_data_i;
        end
    end

`ifdef RV_IMEM_STATS_EN
    logic [31:0] r_fetch_cnt;
    logic [15:0] r_err_cnt;

    assign fetch_cnt_o = r_fetch_cnt;
    assign err_cnt_o   = r_err_cnt;

    // Saturating counters of accepted fetches and of error responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_accept && (r_fetch_cnt != '1)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_resp_entry && w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
